// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//    Shared types and widths for the processor control sequencer.
//    opcode_e     : instruction opcodes understood by the sequencer
//    alu_fcn_e    : function codes driven to the ALU
//    seq_state_e  : one-hot T-step encoding, S_IDLE doubles as T0
//    lastStep()   : the step in which a given opcode pulses done
//    aluFcnOf()   : ALU function code for an ALU opcode
package cpu_ctrl_pkg;

   localparam int NUM_REGS = 8;
   localparam int RSEL_W   = $clog2(NUM_REGS);
   localparam int OPC_W    = 4;
   localparam int FCN_W    = 4;
   localparam int DISP_W   = 4;
   localparam int STEP_W   = 5;

   typedef enum logic [OPC_W-1:0] {
      OP_DISPLAY = 4'd0,
      OP_LOAD    = 4'd1,
      OP_MOVE    = 4'd2,
      OP_ADD     = 4'd3,
      OP_SUB     = 4'd4,
      OP_AND     = 4'd5,
      OP_OR      = 4'd6,
      OP_XOR     = 4'd7,
      OP_NOT     = 4'd8
   } opcode_e;

   typedef enum logic [FCN_W-1:0] {
      FCN_NONE = 4'd0,
      FCN_ADD  = 4'd1,
      FCN_SUB  = 4'd2,
      FCN_AND  = 4'd3,
      FCN_OR   = 4'd4,
      FCN_XOR  = 4'd5,
      FCN_NOT  = 4'd6
   } alu_fcn_e;

   typedef enum logic [STEP_W-1:0] {
      S_IDLE = 5'b00001,
      S_T1   = 5'b00010,
      S_T2   = 5'b00100,
      S_T3   = 5'b01000,
      S_T4   = 5'b10000
   } seq_state_e;

   // Register-only instructions finish in T2, ALU instructions in T4, and
   // unsupported opcodes report illegal and finish immediately in T1.
   function automatic seq_state_e lastStep(input logic [OPC_W-1:0] opc);
      case (opc)
         OP_DISPLAY, OP_LOAD, OP_MOVE:                  return S_T2;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: return S_T4;
         default:                                       return S_T1;
      endcase
   endfunction

   function automatic logic [FCN_W-1:0] aluFcnOf(input logic [OPC_W-1:0] opc);
      case (opc)
         OP_ADD:  return FCN_ADD;
         OP_SUB:  return FCN_SUB;
         OP_AND:  return FCN_AND;
         OP_OR:   return FCN_OR;
         OP_XOR:  return FCN_XOR;
         OP_NOT:  return FCN_NOT;
         default: return FCN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_step_counter.sv
// ctrl_step_counter
//    One-hot T-step register for the control sequencer.
//    clock     : system clock
//    reset     : asynchronous active-high reset, returns to S_IDLE (T0)
//    advance_i : move to the next T-step
//    clear_i   : return to S_IDLE; wins over advance_i
//    step_o    : one-hot {T4..T0}
//    Holding is implicit when neither advance_i nor clear_i is set.
module ctrl_step_counter
   import cpu_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              advance_i,
   input  logic              clear_i,
   output logic [STEP_W-1:0] step_o
);

   seq_state_e state_q;
   seq_state_e state_d;

   // Next step: clear has priority, advance walks T0->T4, otherwise hold.
   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = S_IDLE;
      end else if (advance_i) begin
         case (state_q)
            S_IDLE:  state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Step register with asynchronous return to idle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign step_o = state_q;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//    Self-timed control unit: accepts one instruction via instr_valid/instr_ready,
//    steps through T1..T4 and drives regfile, ALU and display strobes per step.
//    clock, reset            : system clock, asynchronous active-high reset
//    instr_valid/instr_ready : instruction handshake, ready only in IDLE
//    opcode, p1, p2, p3      : instruction fields, latched on accept
//    load_ack                : external data valid on the bus (LOAD waits for it)
//    abort                   : cancel current instruction, back to IDLE, no done
//    data                    : gate external data onto the bus
//    reg_in_en/_sel          : regfile write strobe and index
//    reg_out_en/_sel         : regfile read-to-bus strobe and index
//    alu_a_load/alu_b_load   : latch bus into ALU operand A / B
//    alu_res_out, alu_fcn    : ALU result onto bus, ALU function code
//    display_en/_code        : display latch strobe and mode
//    step                    : one-hot {T4..T0}
//    done, illegal           : one-cycle completion / unsupported-opcode pulses
//    All strobes are Moore outputs of the current step and latched instruction.
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [RSEL_W-1:0] p1,
   input  logic [RSEL_W-1:0] p2,
   input  logic [RSEL_W-1:0] p3,
   input  logic              load_ack,
   input  logic              abort,
   output logic              data,
   output logic              reg_in_en,
   output logic [RSEL_W-1:0] reg_in_sel,
   output logic              reg_out_en,
   output logic [RSEL_W-1:0] reg_out_sel,
   output logic              alu_a_load,
   output logic              alu_b_load,
   output logic              alu_res_out,
   output logic [FCN_W-1:0]  alu_fcn,
   output logic              display_en,
   output logic [DISP_W-1:0] display_code,
   output logic [STEP_W-1:0] step,
   output logic              done,
   output logic              illegal
);

   logic [OPC_W-1:0]  opcode_q;
   logic [RSEL_W-1:0] p1_q;
   logic [RSEL_W-1:0] p2_q;
   logic [RSEL_W-1:0] p3_q;
   logic              advance;
   logic              clear;
   logic              accept;
   seq_state_e        curState;

   ctrl_step_counter u_step (
      .clock     (clock),
      .reset     (reset),
      .advance_i (advance),
      .clear_i   (clear),
      .step_o    (step)
   );

   assign curState = seq_state_e'(step);
   assign accept   = (curState == S_IDLE) && instr_valid;

   // Instruction latch: captured only on accept so later input changes are ignored.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         opcode_q <= '0;
         p1_q     <= '0;
         p2_q     <= '0;
         p3_q     <= '0;
      end else if (accept) begin
         opcode_q <= opcode;
         p1_q     <= p1;
         p2_q     <= p2;
         p3_q     <= p3;
      end
   end

   // Step sequencing: abort and the opcode's last step return to IDLE; LOAD
   // holds in T1 until load_ack, and abort wins over load_ack there.
   always_comb begin
      advance = 1'b0;
      clear   = 1'b0;
      if (curState == S_IDLE) begin
         advance = instr_valid;
      end else if (abort || (curState == lastStep(opcode_q))) begin
         clear = 1'b1;
      end else if (!((opcode_q == OP_LOAD) && (curState == S_T1) && !load_ack)) begin
         advance = 1'b1;
      end
   end

   // Output decode: every strobe defaults low and is raised per opcode and step.
   always_comb begin
      instr_ready  = (curState == S_IDLE);
      data         = 1'b0;
      reg_in_en    = 1'b0;
      reg_in_sel   = '0;
      reg_out_en   = 1'b0;
      reg_out_sel  = '0;
      alu_a_load   = 1'b0;
      alu_b_load   = 1'b0;
      alu_res_out  = 1'b0;
      alu_fcn      = FCN_NONE;
      display_en   = 1'b0;
      display_code = '0;
      done         = 1'b0;
      illegal      = 1'b0;
      case (curState)
         S_T1: begin
            case (opcode_q)
               OP_DISPLAY: begin
                  reg_out_en   = 1'b1;
                  reg_out_sel  = p1_q;
                  display_en   = 1'b1;
                  display_code = {{(DISP_W-RSEL_W){1'b0}}, p2_q};
               end
               OP_LOAD: begin
                  data       = 1'b1;
                  reg_in_en  = 1'b1;
                  reg_in_sel = p1_q;
               end
               OP_MOVE: begin
                  reg_out_en  = 1'b1;
                  reg_out_sel = p1_q;
                  reg_in_en   = 1'b1;
                  reg_in_sel  = p2_q;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                  reg_out_en  = 1'b1;
                  reg_out_sel = p2_q;
                  alu_a_load  = 1'b1;
               end
               default: begin
                  illegal = 1'b1;
                  done    = 1'b1;
               end
            endcase
         end
         S_T2: begin
            case (opcode_q)
               OP_DISPLAY, OP_LOAD, OP_MOVE: done = 1'b1;
               OP_NOT: alu_fcn = aluFcnOf(opcode_q);
               default: begin
                  alu_fcn     = aluFcnOf(opcode_q);
                  reg_out_en  = 1'b1;
                  reg_out_sel = p3_q;
                  alu_b_load  = 1'b1;
               end
            endcase
         end
         S_T3: begin
            alu_res_out = 1'b1;
            reg_in_en   = 1'b1;
            reg_in_sel  = p1_q;
         end
         S_T4: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//    Self-checking bench for control_sequencer: a step-count reference model is
//    compared against every DUT output on every falling edge, and directed
//    scenarios pin the model with literal expectations before a random run.
module tb_control_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       instr_valid = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic [2:0] p1 = 3'd0;
   logic [2:0] p2 = 3'd0;
   logic [2:0] p3 = 3'd0;
   logic       load_ack = 1'b0;
   logic       abort = 1'b0;

   logic       instr_ready, data, reg_in_en, reg_out_en;
   logic [2:0] reg_in_sel, reg_out_sel;
   logic       alu_a_load, alu_b_load, alu_res_out, display_en, done, illegal;
   logic [3:0] alu_fcn, display_code;
   logic [4:0] step;

   int testsRun = 0;
   int failures = 0;
   bit checkEn  = 1'b0;

   control_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .opcode       (opcode),
      .p1           (p1),
      .p2           (p2),
      .p3           (p3),
      .load_ack     (load_ack),
      .abort        (abort),
      .data         (data),
      .reg_in_en    (reg_in_en),
      .reg_in_sel   (reg_in_sel),
      .reg_out_en   (reg_out_en),
      .reg_out_sel  (reg_out_sel),
      .alu_a_load   (alu_a_load),
      .alu_b_load   (alu_b_load),
      .alu_res_out  (alu_res_out),
      .alu_fcn      (alu_fcn),
      .display_en   (display_en),
      .display_code (display_code),
      .step         (step),
      .done         (done),
      .illegal      (illegal)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       ready;
      logic       data;
      logic       rie;
      logic [2:0] ris;
      logic       roe;
      logic [2:0] ros;
      logic       al;
      logic       bl;
      logic       ro;
      logic [3:0] fcn;
      logic       de;
      logic [3:0] dc;
      logic [4:0] step;
      logic       done;
      logic       ill;
   } outs_t;

   outs_t dutOuts;
   assign dutOuts = {instr_ready, data, reg_in_en, reg_in_sel, reg_out_en, reg_out_sel,
                     alu_a_load, alu_b_load, alu_res_out, alu_fcn, display_en,
                     display_code, step, done, illegal};

   // Reference model: an instruction is a number of steps; s is the current
   // step number (0 = idle) and the opcode table says what each step does.
   int         mStep = 0;
   logic [3:0] mOpc  = 4'd0;
   logic [2:0] mA = 3'd0, mB = 3'd0, mC = 3'd0;

   function automatic int stepsFor(input int op);
      if (op <= 2) return 2;
      if (op <= 8) return 4;
      return 1;
   endfunction

   function automatic outs_t expectOuts(input int s, input int op,
                                        input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] c);
      outs_t o;
      o = '0;
      o.step = 5'(1 << s);
      if (s == 0) begin
         o.ready = 1'b1;
      end else if (op > 8) begin
         o.ill  = 1'b1;
         o.done = 1'b1;
      end else if (s == stepsFor(op)) begin
         o.done = 1'b1;
      end else if (op == 0) begin
         o.roe = 1'b1; o.ros = a; o.de = 1'b1; o.dc = {1'b0, b};
      end else if (op == 1) begin
         o.data = 1'b1; o.rie = 1'b1; o.ris = a;
      end else if (op == 2) begin
         o.roe = 1'b1; o.ros = a; o.rie = 1'b1; o.ris = b;
      end else if (s == 1) begin
         o.roe = 1'b1; o.ros = b; o.al = 1'b1;
      end else if (s == 2) begin
         o.fcn = 4'(op - 2);
         if (op != 8) begin
            o.roe = 1'b1; o.ros = c; o.bl = 1'b1;
         end
      end else begin
         o.ro = 1'b1; o.rie = 1'b1; o.ris = a;
      end
      return o;
   endfunction

   // Model step update, sampled on the same edge the DUT acts on.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mStep <= 0;
         mOpc  <= 4'd0;
         mA    <= 3'd0; mB <= 3'd0; mC <= 3'd0;
      end else if (mStep == 0) begin
         if (instr_valid) begin
            mStep <= 1;
            mOpc  <= opcode;
            mA    <= p1; mB <= p2; mC <= p3;
         end
      end else if (abort || mStep == stepsFor(int'(mOpc))) begin
         mStep <= 0;
      end else if (!(mOpc == 4'd1 && mStep == 1 && !load_ack)) begin
         mStep <= mStep + 1;
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   always @(negedge clock) begin
      if (checkEn) begin
         outs_t expOuts;
         expOuts = expectOuts(mStep, int'(mOpc), mA, mB, mC);
         testsRun++;
         if (dutOuts !== expOuts) begin
            failures++;
            $display("[TB] FAIL cycle-compare t=%0t: dut=%h expected=%h (model step %0d opcode %0d)",
                     $time, dutOuts, expOuts, mStep, mOpc);
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [2:0] a,
                                input logic [2:0] b, input logic [2:0] c,
                                input logic ack, input logic ab);
      instr_valid = v;
      opcode      = op;
      p1          = a;
      p2          = b;
      p3          = c;
      load_ack    = ack;
      abort       = ab;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(negedge clock);
   endtask

   initial begin
      #2 reset = 1'b1;
      checkEn = 1'b1;
      nextCycle();
      nextCycle();
      #2 reset = 1'b0;
      nextCycle();
      checkOutput("reset ready", 32'(instr_ready), 32'd1);
      checkOutput("reset step", 32'(step), 32'h01);
      checkOutput("reset done", 32'(done), 32'd0);

      // ADD p1=3 p2=1 p3=2
      applyStimulus(1, 4'd3, 3'd3, 3'd1, 3'd2, 0, 0);
      nextCycle();
      applyStimulus(0, 4'd0, 3'd0, 3'd0, 3'd0, 0, 0);
      checkOutput("add T1 sel/a_load", {reg_out_en, reg_out_sel, alu_a_load, step}, {1'b1, 3'd1, 1'b1, 5'b00010});
      nextCycle();
      checkOutput("add T2 sel/b_load/fcn", {reg_out_sel, alu_b_load, alu_fcn}, {3'd2, 1'b1, 4'd1});
      nextCycle();
      checkOutput("add T3 in_sel/res_out", {reg_in_en, reg_in_sel, alu_res_out}, {1'b1, 3'd3, 1'b1});
      nextCycle();
      checkOutput("add T4 done", {done, step}, {1'b1, 5'b10000});
      nextCycle();
      checkOutput("add back to idle", 32'(instr_ready), 32'd1);

      // Reset mid-ADD at T2
      applyStimulus(1, 4'd3, 3'd3, 3'd1, 3'd2, 0, 0);
      nextCycle();
      applyStimulus(0, 4'd0, 3'd0, 3'd0, 3'd0, 0, 0);
      nextCycle();
      #2 reset = 1'b1;
      #1;
      checkOutput("async reset strobes", {reg_out_en, alu_b_load, alu_fcn, step, instr_ready},
                  {1'b0, 1'b0, 4'd0, 5'b00001, 1'b1});
      nextCycle();
      #2 reset = 1'b0;
      nextCycle();
      checkOutput("after reset release", {instr_ready, step}, {1'b1, 5'b00001});

      // LOAD p1=5, ack held low for 4 cycles
      applyStimulus(1, 4'd1, 3'd5, 3'd0, 3'd0, 0, 0);
      nextCycle();
      applyStimulus(0, 4'd0, 3'd0, 3'd0, 3'd0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("load wait %0d", i), {data, reg_in_en, reg_in_sel, done},
                     {1'b1, 1'b1, 3'd5, 1'b0});
         if (i == 4) load_ack = 1'b1;
         nextCycle();
      end
      load_ack = 1'b0;
      checkOutput("load done", {done, data}, {1'b1, 1'b0});
      nextCycle();

      // Illegal opcode 12
      applyStimulus(1, 4'd12, 3'd1, 3'd2, 3'd3, 0, 0);
      nextCycle();
      applyStimulus(0, 4'd0, 3'd0, 3'd0, 3'd0, 0, 0);
      checkOutput("illegal pulse", {illegal, done, reg_in_en, reg_out_en, alu_a_load, alu_res_out},
                  {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      nextCycle();
      checkOutput("illegal to idle", {instr_ready, step, illegal}, {1'b1, 5'b00001, 1'b0});

      // SUB aborted in T3, then MOVE p1=2 p2=6
      applyStimulus(1, 4'd4, 3'd1, 3'd2, 3'd3, 0, 0);
      nextCycle();
      applyStimulus(0, 4'd0, 3'd0, 3'd0, 3'd0, 0, 0);
      nextCycle();
      nextCycle();
      abort = 1'b1;
      checkOutput("abort cycle follows T3", {alu_res_out, reg_in_sel}, {1'b1, 3'd1});
      nextCycle();
      abort = 1'b0;
      checkOutput("abort to idle no done", {done, instr_ready}, {1'b0, 1'b1});
      applyStimulus(1, 4'd2, 3'd2, 3'd6, 3'd0, 0, 0);
      nextCycle();
      applyStimulus(0, 4'd0, 3'd0, 3'd0, 3'd0, 0, 0);
      checkOutput("move T1", {reg_out_sel, reg_in_sel, reg_out_en, reg_in_en}, {3'd2, 3'd6, 1'b1, 1'b1});
      nextCycle();
      checkOutput("move done", 32'(done), 32'd1);
      nextCycle();

      // Back-to-back DISPLAY with instr_valid held
      applyStimulus(1, 4'd0, 3'd4, 3'd3, 3'd0, 0, 0);
      nextCycle();
      checkOutput("display T1", {display_en, display_code, reg_out_sel, instr_ready},
                  {1'b1, 4'd3, 3'd4, 1'b0});
      nextCycle();
      checkOutput("display done not ready", {done, instr_ready}, {1'b1, 1'b0});
      nextCycle();
      checkOutput("display 2nd accept idle", 32'(instr_ready), 32'd1);
      nextCycle();
      applyStimulus(0, 4'd0, 3'd0, 3'd0, 3'd0, 0, 0);
      checkOutput("display 2nd T1", {display_code, step}, {4'd3, 5'b00010});
      nextCycle();
      nextCycle();

      // Randomized run checked by the cycle compare process
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom % 3) != 0, 4'($urandom_range(0, 15)), 3'($urandom),
                       3'($urandom), 3'($urandom), ($urandom % 4) == 0, ($urandom % 16) == 0);
         nextCycle();
      end
      applyStimulus(0, 4'd0, 3'd0, 3'd0, 3'd0, 1, 0);
      repeat (8) nextCycle();

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
